cpu_fetch: RTL
==============

Name: cpu_fetch

Overview:
Instruction-fetch stage and producer of the decode-stage input bundle (instr, next_PC). It owns the PC, issues one instruction-memory request at a time over a valid/ready request and valid-only response handshake, and buffers one returned word while decode stalls. It redirects on a taken branch from execute and squashes in-flight or held instructions with NOP bubbles.

Parameters:
BOOT_ADDR, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0000, instruction word driven on a bubble

Ports:
clock  input  1  stage clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  32  word-aligned fetch address
imem_resp_valid  input  1  response word valid; at most one per accepted request; never in the same cycle as its acceptance
imem_resp_data  input  32  returned instruction word
stall  input  1  decode cannot accept; output register must hold
branch_taken  input  1  redirect request from execute
branch_target  input  32  redirect PC; bits [1:0] ignored, treated as 0
decode_valid  output  1  decode bundle holds a real instruction
decode_instr  output  32  instruction to decode
decode_next_PC  output  32  fetch address of decode_instr + 4

Behaviour:
- Reset (async, immediate): pc=BOOT_ADDR, state=REQ, drop=0, buffer empty, decode_valid=0, decode_instr=NOP_INSTR, decode_next_PC=BOOT_ADDR+4, imem_req_valid=0 while reset is high.
- State REQ:
  - imem_req_valid = !branch_taken (the only combinational path). imem_req_addr = pc.
  - On valid&&ready, latch req_pc=pc and go to WAIT.
  - A response arriving while in REQ is ignored. This covers a stale response after reset.
- State WAIT:
  - No request.
  - On imem_resp_valid with drop=1: discard the word, clear drop, go to REQ.
  - On imem_resp_valid with drop=0 and output free (stall=0 or decode_valid=0): load decode_instr=data, decode_next_PC=req_pc+4, decode_valid=1. Set pc=req_pc+4 and go to REQ.
  - On imem_resp_valid with drop=0 and stall=1 while decode_valid=1: write the word and req_pc+4 to the one-entry buffer. Set pc=req_pc+4 and go to HOLD.
- State HOLD:
  - No request.
  - When stall=0: the buffer moves into the output register (decode_valid=1), the buffer empties, go to REQ.
- Output register when stall=0 and no new word is loaded: decode_valid<=0 and decode_instr<=NOP_INSTR. Each instruction is presented exactly once.
- stall=1: the decode_* outputs hold their value.
- branch_taken (highest priority, overrides stall in all states):
  - pc <= {branch_target[31:2],2'b00}.
  - Output register <= bubble (valid=0, NOP_INSTR, next_PC=target+4).
  - Buffer cleared.
  - From WAIT without a response this cycle: drop=1, stay in WAIT.
  - From WAIT with a response this cycle: discard it, go to REQ.
  - From HOLD or REQ: go to REQ.
- PC arithmetic is modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0.
- Throughput: maximum one instruction per 2 cycles with zero-latency ready (REQ → WAIT → response). The request for pc+4 issues the cycle after the response.
- Invariants:
  - At most one outstanding request.
  - Never an accepted request while drop=1.
  - Buffer occupied only in HOLD.

Test Plan:
- Reset release, memory ready=1, response 1 cycle after accept → addresses 0,4,8 requested. decode_instr sequence as returned. decode_next_PC 4,8,12. decode_valid pulses, never two consecutive cycles.
- Response 0x1111_1111 for addr 0 arrives while stall=1 and a prior instruction is valid → HOLD, no request. After stall drops: decode_instr=0x1111_1111, next_PC=4. Next request addr=4.
- branch_taken with target 0x0000_0103 while in WAIT. Late response 0xDEAD_BEEF arrives 3 cycles later → word discarded, decode_valid stays 0. Next request addr=0x0000_0100.
- branch_taken and stall both high with buffer full → buffer cleared, output bubble (valid=0, instr=NOP_INSTR). Next request = target.
- req_ready held 0 for 5 cycles → imem_req_valid stays 1, addr stable at pc, no state change. Accept on cycle 6.
- Reset asserted mid-WAIT, then a response arrives after release → response ignored. First request addr=BOOT_ADDR, outputs at reset values.

Source files
------------

// File: rtl/cpu_fetch.sv
// Instruction-fetch stage: owns the PC, issues one imem request at a time and
// presents (instr, next_PC) to decode, buffering one word while decode stalls.
module cpu_fetch #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        decode_valid,
  output logic [31:0] decode_instr,
  output logic [31:0] decode_next_PC
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] req_pc;
  logic        drop;
  logic [31:0] buf_instr;
  logic [31:0] buf_next_pc;

  logic [31:0] target;
  logic [31:0] seq_pc;
  logic        accept;
  logic        out_free;

  assign target   = {branch_target[31:2], 2'b00};
  assign seq_pc   = req_pc + 32'd4;
  assign accept   = imem_req_valid && imem_req_ready;
  assign out_free = !stall || !decode_valid;

  // A redirect in the same cycle suppresses the request so the old PC is never accepted.
  assign imem_req_valid = (state == S_REQ) && !branch_taken && !reset;
  assign imem_req_addr  = pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= S_REQ;
      pc             <= BOOT_ADDR;
      req_pc         <= BOOT_ADDR;
      drop           <= 1'b0;
      buf_instr      <= NOP_INSTR;
      buf_next_pc    <= '0;
      decode_valid   <= 1'b0;
      decode_instr   <= NOP_INSTR;
      decode_next_PC <= BOOT_ADDR + 32'd4;
    end else if (branch_taken) begin
      pc             <= target;
      decode_valid   <= 1'b0;
      decode_instr   <= NOP_INSTR;
      decode_next_PC <= target + 32'd4;
      buf_instr      <= NOP_INSTR;
      buf_next_pc    <= '0;
      // Still owed a response for the killed request: remember to discard it.
      if (state == S_WAIT && !imem_resp_valid) begin
        drop  <= 1'b1;
        state <= S_WAIT;
      end else begin
        drop  <= 1'b0;
        state <= S_REQ;
      end
    end else begin
      if (!stall) begin
        decode_valid <= 1'b0;
        decode_instr <= NOP_INSTR;
      end
      unique case (state)
        S_REQ: begin
          if (accept) begin
            req_pc <= pc;
            state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (drop) begin
              drop  <= 1'b0;
              state <= S_REQ;
            end else begin
              pc <= seq_pc;
              if (out_free) begin
                decode_valid   <= 1'b1;
                decode_instr   <= imem_resp_data;
                decode_next_PC <= seq_pc;
                state          <= S_REQ;
              end else begin
                buf_instr   <= imem_resp_data;
                buf_next_pc <= seq_pc;
                state       <= S_HOLD;
              end
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            decode_valid   <= 1'b1;
            decode_instr   <= buf_instr;
            decode_next_PC <= buf_next_pc;
            buf_instr      <= NOP_INSTR;
            buf_next_pc    <= '0;
            state          <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule
